// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame width and baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;

  function automatic int clks_per_bit(input int clock_freq, input int baud);
    return clock_freq / baud;
  endfunction

endpackage

// File: rtl/uart_input_synchronizer.sv
// Two-flop synchroniser for an asynchronous UART-side input; both flops reset
// to 1 so an idle-high line never looks like a start bit out of reset.
module uart_input_synchronizer (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver with a one-byte holding register on a valid/ready handshake.
//
//  state | meaning
//  IDLE  | line idle, waiting for a falling edge on rx_s
//  START | timing to mid start bit to reject glitches
//  DATA  | sampling 8 data bits at mid-bit, LSB first
//  STOP  | sampling the stop bit at mid-bit
//  BREAK | stop bit was 0; waiting for the line to return high
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115_200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_receive,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int TIMER_W      = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] HALF_BIT = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] FULL_BIT = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]         LAST_BIT = 3'(UART_DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("uart_byte_receiver: CLKS_PER_BIT must be >= 4");
    end
  endgenerate

  logic rx_s;

  uart_input_synchronizer u_rx_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (uart_receive),
    .sync_out (rx_s)
  );

  rx_state_t                 state_q, state_d;
  logic [TIMER_W-1:0]        timer_q, timer_d;
  logic [2:0]                index_q, index_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      oerr_q, oerr_d;
  logic                      deliver;
  logic                      frame_bad;
  logic                      accept;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    index_d   = index_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (timer_q == HALF_BIT) begin
          timer_d = '0;
          index_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_q == FULL_BIT) begin
          timer_d = '0;
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          if (index_q == LAST_BIT) state_d = STOP;
          else                     index_d = index_q + 3'd1;
        end
      end
      STOP: begin
        if (timer_q == FULL_BIT) begin
          timer_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        timer_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // A byte completing while the held byte is not being taken is dropped.
  always_comb begin
    accept  = valid_q & data_ready;
    data_d  = data_q;
    valid_d = valid_q & ~accept;
    ferr_d  = frame_bad;
    oerr_d  = 1'b0;
    if (deliver) begin
      if (valid_q && !accept) begin
        oerr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      index_q <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      index_q <= index_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

  assign data          = data_q;
  assign data_valid    = valid_q;
  assign framing_error = ferr_q;
  assign overrun_error = oerr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Scenario bench for uart_byte_receiver at 10 clocks per bit; expected bytes are
// queued as frames are sent and popped when the DUT hands a byte over.
module tb_uart_byte_receiver;

  localparam int CPB = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       uart_receive;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       framing_error;
  logic       overrun_error;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         accept_cnt = 0;
  int         ferr_cnt = 0;
  int         oerr_cnt = 0;
  logic [7:0] last_data = 8'hxx;
  logic       hold_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_byte_receiver #(
    .CLOCK_FREQUENCY (100),
    .BAUD_RATE       (10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .uart_receive  (uart_receive),
    .data          (data),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // Scoreboard and handshake-stability monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        checks++;
        if (data !== prev_data || data_valid !== 1'b1) begin
          errors++;
          $display("FAIL hold_stable: data=%h valid=%b, required data=%h valid=1",
                   data, data_valid, prev_data);
        end
      end
      if (data_valid === 1'b1 && data_ready === 1'b1) begin
        accept_cnt++;
        last_data = data;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %h, required no byte", data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data !== e) begin
            errors++;
            $display("FAIL byte_order: got %h, required %h", data, e);
          end
        end
      end
      if (framing_error === 1'b1) ferr_cnt++;
      if (overrun_error === 1'b1) oerr_cnt++;
      hold_prev = (data_valid === 1'b1) && (data_ready === 1'b0);
      prev_data = data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_bits);
    uart_receive = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_receive = b[i];
      tick(CPB);
    end
    uart_receive = stop_val;
    tick(CPB * stop_bits);
    uart_receive = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d bytes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    uart_receive = 1'b1;
    data_ready = 1'b1;
    tick(3);
    checks++;
    if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, required 00", data); end
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", data_valid); end
    checks++;
    if (framing_error !== 1'b0 || overrun_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_errors: got ferr=%b oerr=%b, required 0 0", framing_error, overrun_error);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    reset = 1'b0;
    tick(3);
  endtask

  task automatic test_single_byte();
    int a0 = accept_cnt, f0 = ferr_cnt, o0 = oerr_cnt;
    data_ready = 1'b1;
    exp_q.push_back(8'h48);
    send_byte(8'h48, 1'b1, 1);
    drain("single");
    tick(CPB);
    check_int("single_accepts", accept_cnt - a0, 1);
    check_int("single_ferr", ferr_cnt - f0, 0);
    check_int("single_oerr", oerr_cnt - o0, 0);
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL single_valid_clear: got %b, required 0", data_valid); end
  endtask

  task automatic test_string();
    string s = "Hellllooooooooo";
    int a0 = accept_cnt, f0 = ferr_cnt, o0 = oerr_cnt;
    data_ready = 1'b1;
    for (int i = 0; i < s.len(); i++) begin
      exp_q.push_back(8'(s[i]));
      send_byte(8'(s[i]), 1'b1, 2);
    end
    exp_q.push_back(8'h00);
    send_byte(8'h00, 1'b1, 2);
    drain("string");
    check_int("string_accepts", accept_cnt - a0, s.len() + 1);
    check_int("string_last", int'(last_data), 0);
    check_int("string_errors", (ferr_cnt - f0) + (oerr_cnt - o0), 0);
  endtask

  task automatic test_back_to_back();
    int a0 = accept_cnt;
    logic [7:0] pat[4];
    pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'h01; pat[3] = 8'h80;
    data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pat[i]);
      send_byte(pat[i], 1'b1, 1);
    end
    drain("b2b");
    check_int("b2b_accepts", accept_cnt - a0, 4);
  endtask

  task automatic test_overrun();
    int a0 = accept_cnt, o0 = oerr_cnt, f0 = ferr_cnt;
    data_ready = 1'b0;
    exp_q.push_back(8'h65);
    send_byte(8'h65, 1'b1, 1);
    send_byte(8'h6C, 1'b1, 1);
    tick(5);
    checks++;
    if (data !== 8'h65 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_held: got data=%h valid=%b, required 65 1", data, data_valid);
    end
    check_int("overrun_pulses", oerr_cnt - o0, 1);
    check_int("overrun_ferr", ferr_cnt - f0, 0);
    check_int("overrun_no_accept", accept_cnt - a0, 0);
    data_ready = 1'b1;
    tick(1);
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL overrun_release_valid: got %b, required 0", data_valid); end
    check_int("overrun_accepts", accept_cnt - a0, 1);
    drain("overrun");
  endtask

  task automatic test_framing();
    int a0 = accept_cnt, f0 = ferr_cnt, o0 = oerr_cnt;
    data_ready = 1'b1;
    send_byte(8'h55, 1'b0, 4);
    tick(2 * CPB);
    check_int("framing_pulses", ferr_cnt - f0, 1);
    check_int("framing_no_data", accept_cnt - a0, 0);
    check_int("framing_oerr", oerr_cnt - o0, 0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL framing_recover_busy: got %b, required 0", busy); end
    exp_q.push_back(8'h6F);
    send_byte(8'h6F, 1'b1, 1);
    drain("framing");
    check_int("framing_next_accepts", accept_cnt - a0, 1);
  endtask

  task automatic test_glitch();
    int a0 = accept_cnt, f0 = ferr_cnt, o0 = oerr_cnt;
    uart_receive = 1'b0;
    tick(3);
    uart_receive = 1'b1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy: got %b, required 1", busy); end
    tick(2 * CPB);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b, required 0", busy); end
    check_int("glitch_events", (accept_cnt - a0) + (ferr_cnt - f0) + (oerr_cnt - o0), 0);
  endtask

  task automatic test_reset_mid_frame();
    int a0 = accept_cnt, f0 = ferr_cnt;
    data_ready = 1'b1;
    uart_receive = 1'b0;
    tick(CPB);
    uart_receive = 1'b1;
    tick(4 * CPB + CPB / 2);
    reset = 1'b1;
    tick(2);
    checks++;
    if (busy !== 1'b0 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: got busy=%b valid=%b, required 0 0", busy, data_valid);
    end
    reset = 1'b0;
    tick(4 * CPB);
    exp_q.push_back(8'h00);
    send_byte(8'h00, 1'b1, 1);
    drain("midreset");
    check_int("midreset_accepts", accept_cnt - a0, 1);
    check_int("midreset_ferr", ferr_cnt - f0, 0);
  endtask

  initial begin
    reset = 1'b1;
    uart_receive = 1'b1;
    data_ready = 1'b1;
    tick(1);
    test_reset();
    test_single_byte();
    test_string();
    test_back_to_back();
    test_overrun();
    test_framing();
    test_glitch();
    test_reset_mid_frame();
    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
